// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg: shared FSM state encoding and default timing constants
package btn_conditioner_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 20;
  localparam int LONG_CYCLES_DEF = 2000;
endpackage

// File: rtl/btn_chan.sv
// btn_chan: one button channel - two-flop synchroniser, debounce FSM, hold counter
module btn_chan
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic lng
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  logic [1:0] sync;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  state_t state;
  logic s;
  assign s = sync[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      state <= IDLE;
      dcnt <= '0;
      hcnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rls <= 1'b0;
      lng <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      press <= 1'b0;
      rls <= 1'b0;
      lng <= 1'b0;
      // hold time keeps accruing through release bounces; a release accepted later suppresses lng
      if ((state == HELD || state == RELEASE_WAIT) && hcnt != HW'(LONG_CYCLES)) begin
        hcnt <= hcnt + 1'b1;
        lng <= (hcnt == HW'(LONG_CYCLES - 1));
      end
      case (state)
        IDLE:
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= HELD;
              level <= 1'b1;
              press <= 1'b1;
              hcnt <= '0;
            end else begin
              state <= PRESS_WAIT;
              dcnt <= DW'(1);
            end
          end
        PRESS_WAIT:
          if (!s) begin
            state <= IDLE;
            dcnt <= '0;
          end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state <= HELD;
            dcnt <= '0;
            level <= 1'b1;
            press <= 1'b1;
            hcnt <= '0;
          end else dcnt <= dcnt + 1'b1;
        HELD:
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= IDLE;
              level <= 1'b0;
              rls <= 1'b1;
              lng <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
              dcnt <= DW'(1);
            end
          end
        RELEASE_WAIT:
          if (s) begin
            state <= HELD;
            dcnt <= '0;
          end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state <= IDLE;
            dcnt <= '0;
            level <= 1'b0;
            rls <= 1'b1;
            lng <= 1'b0;
          end else dcnt <= dcnt + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent debounced button channels with press/release/long pulses
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rls(btn_release[i]),
      .lng(btn_long[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboarded random/directed bench against a run-length reference model
module tb_btn_conditioner;
  localparam int N = 5, D = 4, L = 16;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] raw = '0, level, press, rls, lng;
  typedef struct packed {logic [N-1:0] lv, pr, rl, lg;} out_t;
  out_t exp_q[$];
  out_t e, got;
  int errs = 0, checks = 0;
  int run[N], hold[N];
  bit mlev[N], p1[N], p2[N];

  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw), .btn_level(level),
    .btn_press(press), .btn_release(rls), .btn_long(lng)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      run[c] = 0; hold[c] = 0; mlev[c] = 0; p1[c] = 0; p2[c] = 0;
    end
  endtask

  // Reference: a level flips after D consecutive synchronised samples disagreeing with it;
  // long fires when the hold since the accepted press reaches exactly L with level still high.
  always @(posedge clk) begin
    e = '0;
    if (!rst_n) model_clear();
    else for (int c = 0; c < N; c++) begin
      bit s;
      s = p2[c]; p2[c] = p1[c]; p1[c] = raw[c];
      run[c] = (s != mlev[c]) ? run[c] + 1 : 0;
      if (run[c] == D) begin
        run[c] = 0;
        mlev[c] = s;
        if (s) begin e.pr[c] = 1; hold[c] = 0; end
        else e.rl[c] = 1;
      end else if (mlev[c]) begin
        hold[c]++;
        e.lg[c] = (hold[c] == L);
      end
      e.lv[c] = mlev[c];
    end
    exp_q.push_back(e);
  end

  always @(negedge rst_n) begin
    model_clear();
    exp_q.delete();
  end

  always @(negedge clk) begin
    got = {level, press, rls, lng};
    if (exp_q.size() != 0) chk("outputs{lv,pr,rl,lg}", 32'(got), 32'(exp_q.pop_front()));
    else if (!rst_n) chk("outputs_in_reset", 32'(got), 32'd0);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1 chk("reset_outputs", 32'({level, press, rls, lng}), 32'd0);
    cyc(3);
    rst_n = 1;
    cyc(2);
    raw[1] = 1; cyc(10); raw[1] = 0; cyc(10);
    raw[0] = 1; cyc(3); raw[0] = 0; cyc(10);
    raw[2] = 1; cyc(10); raw[2] = 0; cyc(1); raw[2] = 1; cyc(2); raw[2] = 0; cyc(10);
    raw[3] = 1; cyc(30); raw[3] = 0; cyc(10);
    raw[4] = 1; cyc(10);
    chk("level4_before_reset", 32'(level[4]), 32'd1);
    rst_n = 0;
    #1 chk("async_reset_outputs", 32'({level, press, rls, lng}), 32'd0);
    cyc(2);
    rst_n = 1;
    cyc(10); raw[4] = 0; cyc(10);
    raw = '1; cyc(8); raw = '0; cyc(10);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(2) == 0) raw[c] = ~raw[c];
      cyc(1);
    end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(29) == 0) raw[c] = ~raw[c];
      if (i == 1500) begin
        rst_n = 0;
        #1 chk("random_async_reset", 32'({level, press, rls, lng}), 32'd0);
        cyc(1);
        rst_n = 1;
      end
      cyc(1);
    end
    raw = '0;
    cyc(12);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
